// File: rtl/uart_dump_ctrl.sv
// Dump sequencer for the UART monitor: reads words from start_adr to end_adr through a
// fixed-latency read port and streams them as lowercase hex ASCII, WORDS_PER_LINE words per line.
module uart_dump_ctrl #(
  parameter int RD_LAT         = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] uart_data,
  input  logic        read_start_set,
  input  logic        read_end_set,
  input  logic        read_stop,
  output logic        dump_running,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  typedef enum logic [2:0] {IDLE, RDREQ, RDWAIT, HEX, SEP, CR, LF} state_t;

  localparam logic [31:0] TOP_ADR  = 32'hffff_fffc;
  localparam logic [2:0]  LAT_LAST = 3'(RD_LAT - 1);
  localparam logic [2:0]  WPL_LAST = 3'(WORDS_PER_LINE - 1);

  state_t      state, state_d;
  logic [31:0] start_adr, start_adr_d;
  logic [31:0] end_adr, end_adr_d;
  logic [31:0] cur_adr, cur_adr_d;
  logic [31:0] shift, shift_d;
  logic [2:0]  word_cnt, word_cnt_d;
  logic [2:0]  nib_cnt, nib_cnt_d;
  logic [2:0]  lat_cnt, lat_cnt_d;
  logic [7:0]  tx_data_d;
  logic        tx_valid_d;
  logic        stop_pend, stop_pend_d;
  logic        xfer, last_word;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction

  assign xfer         = tx_valid & tx_ready;
  // A reversed range (end below start) ends on the very first word.
  assign last_word    = (cur_adr >= end_adr) || (cur_adr == TOP_ADR);
  assign dump_running = (state != IDLE);
  assign mem_re       = (state == RDREQ);
  assign mem_addr     = cur_adr;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves a latch behind.
    state_d     = state;
    start_adr_d = start_adr;
    end_adr_d   = end_adr;
    cur_adr_d   = cur_adr;
    shift_d     = shift;
    word_cnt_d  = word_cnt;
    nib_cnt_d   = nib_cnt;
    lat_cnt_d   = lat_cnt;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    stop_pend_d = stop_pend;

    case (state)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (read_start_set) start_adr_d = uart_data & ~32'h3;
        if (read_end_set) begin
          end_adr_d  = uart_data & ~32'h3;
          cur_adr_d  = start_adr;
          word_cnt_d = '0;
          state_d    = RDREQ;
        end
      end
      RDREQ: begin
        lat_cnt_d = '0;
        state_d   = read_stop ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        if (read_stop) begin
          state_d = IDLE;
        end else if (lat_cnt == LAT_LAST) begin
          shift_d    = mem_rdata;
          nib_cnt_d  = '0;
          tx_data_d  = hex_char(mem_rdata[31:28]);
          tx_valid_d = 1'b1;
          state_d    = HEX;
        end else begin
          lat_cnt_d = lat_cnt + 3'd1;
        end
      end
      default: begin
        if (xfer) begin
          case (state)
            HEX: begin
              shift_d   = shift << 4;
              nib_cnt_d = nib_cnt + 3'd1;
              if (nib_cnt == 3'd7) begin
                tx_data_d = 8'h20;
                state_d   = SEP;
              end else begin
                tx_data_d = hex_char(shift[27:24]);
              end
            end
            SEP: begin
              if (last_word || word_cnt == WPL_LAST) begin
                word_cnt_d = '0;
                tx_data_d  = 8'h0d;
                state_d    = CR;
              end else begin
                word_cnt_d = word_cnt + 3'd1;
                cur_adr_d  = cur_adr + 32'd4;
                tx_valid_d = 1'b0;
                state_d    = RDREQ;
              end
            end
            CR: begin
              tx_data_d = 8'h0a;
              state_d   = LF;
            end
            LF: begin
              tx_valid_d = 1'b0;
              if (last_word) begin
                state_d = IDLE;
              end else begin
                cur_adr_d = cur_adr + 32'd4;
                state_d   = RDREQ;
              end
            end
            default: ;
          endcase
          // A stop waits for the character on the wire, then abandons the rest.
          if (read_stop || stop_pend) begin
            tx_valid_d  = 1'b0;
            stop_pend_d = 1'b0;
            state_d     = IDLE;
          end
        end else if (read_stop) begin
          stop_pend_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      start_adr <= '0;
      end_adr   <= '0;
      cur_adr   <= '0;
      shift     <= '0;
      word_cnt  <= '0;
      nib_cnt   <= '0;
      lat_cnt   <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_d;
      start_adr <= start_adr_d;
      end_adr   <= end_adr_d;
      cur_adr   <= cur_adr_d;
      shift     <= shift_d;
      word_cnt  <= word_cnt_d;
      nib_cnt   <= nib_cnt_d;
      lat_cnt   <= lat_cnt_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      stop_pend <= stop_pend_d;
    end
  end

endmodule

// File: tb/tb_uart_dump_ctrl.sv
// Bench for uart_dump_ctrl: a text-level model of the dump stream and read addresses,
// checked every cycle, plus literal expectations for the directed dumps.
module tb_uart_dump_ctrl;

  localparam int RD_LAT = 2;
  localparam int WPL    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] uart_data;
  logic        read_start_set, read_end_set, read_stop;
  logic        dump_running;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  uart_dump_ctrl #(.RD_LAT(RD_LAT), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .rst(rst), .uart_data(uart_data),
    .read_start_set(read_start_set), .read_end_set(read_end_set), .read_stop(read_stop),
    .dump_running(dump_running), .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // Memory: contents are either the word's own address or a fixed pattern.
  int mem_mode = 0;
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (mem_mode == 1) ? 32'hdeadbeef : a;
  endfunction

  logic [31:0] pipe_d [RD_LAT];
  logic        pipe_v [RD_LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= mem_re;
      pipe_d[0] <= mem_val(mem_addr);
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end
  assign mem_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'h5a5a_5a5a;

  // Transmitter readiness: 0 = always ready, 1 = ready one cycle in three, 2 = driven by hand.
  int ready_mode = 0;
  int cyc = 0;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready_mode == 0) tx_ready = 1'b1;
      else if (ready_mode == 1) tx_ready = (cyc % 3 == 0);
    end
  end

  // Model: the text a dump of [s..e] must produce, and the word addresses it must read.
  logic [7:0]  exp_chars[$];
  logic [31:0] exp_addrs[$];
  string       exp_str;
  string       got;

  task automatic build_expect(input logic [31:0] s, input logic [31:0] e);
    logic [31:0] a;
    int          n;
    exp_str = "";
    a = s;
    n = 0;
    forever begin
      exp_addrs.push_back(a);
      exp_str = {exp_str, $sformatf("%08h ", mem_val(a))};
      n++;
      if (a >= e || a == 32'hffff_fffc) begin
        exp_str = {exp_str, "\015\012"};
        break;
      end
      if (n % WPL == 0) exp_str = {exp_str, "\015\012"};
      a = a + 32'd4;
    end
    for (int i = 0; i < exp_str.len(); i++) exp_chars.push_back(exp_str[i]);
  endtask

  // After a transfer: 1 = next char must follow at once, 2 = gap for a read, 3 = dump over.
  bit          cmp_en = 1'b0;
  int          exp_after = 0;
  bit          stall_prev = 1'b0;
  logic [7:0]  stall_data;

  always @(negedge clk) begin
    if (cmp_en) begin
      case (exp_after)
        1: check("tx_valid_back_to_back", tx_valid, 1);
        2: check("tx_valid_gap", tx_valid, 0);
        3: begin
          check("tx_valid_end", tx_valid, 0);
          check("dump_running_end", dump_running, 0);
        end
        default: ;
      endcase
      exp_after = 0;
      if (stall_prev) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, stall_data);
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_chars.size() == 0) begin
          check("extra_char", 1, 0);
        end else begin
          logic [7:0] c;
          c = exp_chars.pop_front();
          check("tx_char", tx_data, c);
          got = $sformatf("%s%c", got, tx_data);
          if (exp_chars.size() == 0) exp_after = 3;
          else if ((c == 8'h20 && exp_chars[0] != 8'h0d) || c == 8'h0a) exp_after = 2;
          else exp_after = 1;
        end
      end
      if (mem_re) begin
        if (exp_addrs.size() == 0) check("extra_mem_re", 1, 0);
        else check("mem_addr", mem_addr, exp_addrs.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input logic [31:0] s, input logic [31:0] e);
    got = "";
    tick();
    uart_data = s;
    read_start_set = 1'b1;
    tick();
    read_start_set = 1'b0;
    uart_data = e;
    read_end_set = 1'b1;
    tick();
    read_end_set = 1'b0;
    uart_data = '0;
    @(negedge clk);
    check("dump_running_rise", dump_running, 1);
  endtask

  task automatic run_dump(input logic [31:0] s, input logic [31:0] e, input bit poke);
    bit done;
    build_expect(s & ~32'h3, e & ~32'h3);
    start_dump(s, e);
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      // Mid-dump start/end pulses must be ignored.
      read_start_set = poke && (i == 20);
      read_end_set   = poke && (i == 20);
      uart_data      = (poke && i == 20) ? 32'h500 : 32'h0;
      if (!dump_running && exp_chars.size() == 0 && exp_addrs.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    read_start_set = 1'b0;
    read_end_set   = 1'b0;
    check("dump_done", done, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dump_running"}, dump_running, 0);
    check({tag, "_mem_re"}, mem_re, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    uart_data = '0;
    read_start_set = 1'b0;
    read_end_set = 1'b0;
    read_stop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    cmp_en = 1'b1;

    // read_stop in IDLE does nothing.
    tick();
    read_stop = 1'b1;
    tick();
    read_stop = 1'b0;
    @(negedge clk);
    check("stop_in_idle", dump_running, 0);

    // Four words on one line; the start address carries stray low bits.
    mem_mode = 0;
    run_dump(32'h103, 32'h10c, 1'b0);
    check_str("t1_text", got, "00000100 00000104 00000108 0000010c \015\012");
    check("t1_len", got.len(), 38);

    // Six words: line break after the fourth and after the sixth.
    run_dump(32'h0, 32'h14, 1'b1);
    check_str("t2_text", got,
              "00000000 00000004 00000008 0000000c \015\01200000010 00000014 \015\012");

    // Stalling transmitter.
    mem_mode = 1;
    ready_mode = 1;
    run_dump(32'h40, 32'h40, 1'b0);
    check_str("t3_text", got, "deadbeef \015\012");
    ready_mode = 0;

    // Stop while the third hex char is stalled.
    ready_mode = 2;
    tx_ready = 1'b0;
    build_expect(32'h80, 32'h84);
    while (exp_chars.size() > 3) void'(exp_chars.pop_back());
    while (exp_addrs.size() > 1) void'(exp_addrs.pop_back());
    start_dump(32'h80, 32'h84);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("t4_valid_seen", seen, 1);
    tick();
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    tick();
    read_stop = 1'b1;
    tick();
    read_stop = 1'b0;
    tick();
    tick();
    tx_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("t4_dump_running", dump_running, 0);
    check("t4_tx_valid", tx_valid, 0);
    check("t4_chars_left", exp_chars.size(), 0);
    check_str("t4_text", got, "dea");
    ready_mode = 0;

    // Reversed range and top-of-memory word.
    mem_mode = 0;
    run_dump(32'h20, 32'h10, 1'b0);
    check_str("t5_reversed", got, "00000020 \015\012");
    run_dump(32'hffff_fffc, 32'hffff_fffc, 1'b0);
    check_str("t5_top", got, "fffffffc \015\012");

    // Reset in the middle of a word, then a clean dump.
    build_expect(32'h200, 32'h20c);
    start_dump(32'h200, 32'h20c);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_valid_seen", seen, 1);
    @(negedge clk);
    cmp_en = 1'b0;
    tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("t6_reset");
    rst = 1'b0;
    exp_chars.delete();
    exp_addrs.delete();
    exp_after = 0;
    stall_prev = 1'b0;
    cmp_en = 1'b1;
    run_dump(32'h100, 32'h10c, 1'b0);
    check_str("t6_text", got, "00000100 00000104 00000108 0000010c \015\012");

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
